// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter_if
// Brief    : Fetch, memory-stage and memory-bus signals of mem_port_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic              f_req;
  logic [ADDR_W-1:0] f_addr;
  logic              f_valid;
  logic [DATA_W-1:0] f_rdata;
  logic              f_err;
  logic              f_wait;

  logic              m_req;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic              m_valid;
  logic [DATA_W-1:0] m_rdata;
  logic              m_err;
  logic              m_wait;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  // Arbiter side
  modport slave (
    input  f_req, f_addr,
    output f_valid, f_rdata, f_err, f_wait,
    input  m_req, m_we, m_addr, m_wdata,
    output m_valid, m_rdata, m_err, m_wait,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  // Requesters and memory side
  modport master (
    output f_req, f_addr,
    input  f_valid, f_rdata, f_err, f_wait,
    output m_req, m_we, m_addr, m_wdata,
    input  m_valid, m_rdata, m_err, m_wait,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Single-port memory shared by fetch (read) and memory stage (r/w),
//            one transaction in flight, with bus timeout reporting.
//            Optional macro FETCH_STARVE_GUARD_EN forces a fetch grant after
//            STARVE_MAX memory-stage grants made while fetch was waiting.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int TIMEOUT    = 16,
  parameter int STARVE_MAX = 4
) (
  input  wire logic          clk,
  input  wire logic          rst,
  mem_port_arbiter_if.slave  bus
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] C_TMO_LAST = CNT_W'(TIMEOUT - 1);

  if (TIMEOUT < 2 || STARVE_MAX < 1) begin : g_param_check
    $error("mem_port_arbiter: TIMEOUT must be >= 2 and STARVE_MAX >= 1");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_F = 2'd1,
    BUSY_M = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  tmo_q, tmo_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              f_valid_q, f_valid_d;
  logic              f_err_q, f_err_d;
  logic [DATA_W-1:0] f_rdata_q, f_rdata_d;
  logic              m_valid_q, m_valid_d;
  logic              m_err_q, m_err_d;
  logic [DATA_W-1:0] m_rdata_q, m_rdata_d;

  logic w_f_elig, w_m_elig, w_grant_f, w_grant_m, w_force_f;

  // A request seen alongside its own valid pulse belongs to the finished transaction
  assign w_f_elig  = bus.f_req & ~f_valid_q;
  assign w_m_elig  = bus.m_req & ~m_valid_q;
  assign w_grant_m = (state_q == IDLE) & w_m_elig & ~w_force_f;
  assign w_grant_f = (state_q == IDLE) & w_f_elig & ~w_grant_m;

`ifdef FETCH_STARVE_GUARD_EN
  localparam int STARVE_W = $clog2(STARVE_MAX + 1);
  localparam logic [STARVE_W-1:0] C_STARVE_LIM = STARVE_W'(STARVE_MAX);

  logic [STARVE_W-1:0] starve_q, starve_d;

  assign w_force_f = w_f_elig & (starve_q == C_STARVE_LIM);

  always_comb begin
    starve_d = starve_q;
    if (w_grant_f)
      starve_d = '0;
    else if (w_grant_m && w_f_elig && starve_q != C_STARVE_LIM)
      starve_d = starve_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) starve_q <= '0;
    else     starve_q <= starve_d;
  end
`else
  assign w_force_f = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    tmo_d       = tmo_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    f_valid_d   = 1'b0;
    f_err_d     = 1'b0;
    f_rdata_d   = '0;
    m_valid_d   = 1'b0;
    m_err_d     = 1'b0;
    m_rdata_d   = '0;
    case (state_q)
      IDLE: begin
        if (w_grant_m) begin
          state_d     = BUSY_M;
          tmo_d       = '0;
          mem_req_d   = 1'b1;
          mem_we_d    = bus.m_we;
          mem_addr_d  = bus.m_addr;
          mem_wdata_d = bus.m_wdata;
        end else if (w_grant_f) begin
          state_d     = BUSY_F;
          tmo_d       = '0;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = bus.f_addr;
          mem_wdata_d = '0;
        end
      end
      BUSY_F, BUSY_M: begin
        // An ack on the last allowed cycle still counts as normal completion
        if (bus.mem_ack || tmo_q == C_TMO_LAST) begin
          state_d   = IDLE;
          tmo_d     = '0;
          mem_req_d = 1'b0;
          if (state_q == BUSY_F) begin
            f_valid_d = 1'b1;
            f_err_d   = ~bus.mem_ack;
            f_rdata_d = bus.mem_ack ? bus.mem_rdata : '0;
          end else begin
            m_valid_d = 1'b1;
            m_err_d   = ~bus.mem_ack;
            m_rdata_d = (bus.mem_ack && !mem_we_q) ? bus.mem_rdata : '0;
          end
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      tmo_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      f_valid_q   <= 1'b0;
      f_err_q     <= 1'b0;
      f_rdata_q   <= '0;
      m_valid_q   <= 1'b0;
      m_err_q     <= 1'b0;
      m_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      tmo_q       <= tmo_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      f_valid_q   <= f_valid_d;
      f_err_q     <= f_err_d;
      f_rdata_q   <= f_rdata_d;
      m_valid_q   <= m_valid_d;
      m_err_q     <= m_err_d;
      m_rdata_q   <= m_rdata_d;
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.f_valid   = f_valid_q;
  assign bus.f_err     = f_err_q;
  assign bus.f_rdata   = f_rdata_q;
  assign bus.f_wait    = bus.f_req & ~f_valid_q;
  assign bus.m_valid   = m_valid_q;
  assign bus.m_err     = m_err_q;
  assign bus.m_rdata   = m_rdata_q;
  assign bus.m_wait    = bus.m_req & ~m_valid_q;
endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Brief    : Randomized requesters and memory against a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;
  localparam int ADDR_W     = 64;
  localparam int DATA_W     = 64;
  localparam int TIMEOUT    = 16;
  localparam int STARVE_MAX = 4;
  localparam int NEVER      = 1000000;
  localparam int N_CYCLES   = 4000;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Model: who owns the memory (0 none, 1 fetch, 2 memory stage) and when it was granted
  int          owner;
  int          grant_cyc;
  int          ack_at;
  int          starve;
  int          cyc;
  logic        e_we;
  logic [63:0] e_addr, e_wdata;
  logic        e_fv, e_fe, e_mv, e_me;
  logic [63:0] e_fr, e_mr;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  task automatic model_reset();
    owner = 0; grant_cyc = 0; ack_at = NEVER; starve = 0;
    e_we = 1'b0; e_addr = '0; e_wdata = '0;
    e_fv = 1'b0; e_fe = 1'b0; e_fr = '0;
    e_mv = 1'b0; e_me = 1'b0; e_mr = '0;
  endtask

  task automatic clear_inputs();
    bus.f_req = 1'b0; bus.f_addr = '0;
    bus.m_req = 1'b0; bus.m_we = 1'b0; bus.m_addr = '0; bus.m_wdata = '0;
    bus.mem_ack = 1'b0; bus.mem_rdata = '0;
  endtask

  task automatic check_outputs();
    check_eq("mem_req", {63'd0, bus.mem_req}, {63'd0, owner != 0});
    if (owner != 0) begin
      check_eq("mem_we", {63'd0, bus.mem_we}, {63'd0, e_we});
      check_eq("mem_addr", bus.mem_addr, e_addr);
      check_eq("mem_wdata", bus.mem_wdata, e_wdata);
    end
    check_eq("f_valid", {63'd0, bus.f_valid}, {63'd0, e_fv});
    check_eq("f_err", {63'd0, bus.f_err}, {63'd0, e_fe});
    check_eq("f_rdata", bus.f_rdata, e_fr);
    check_eq("m_valid", {63'd0, bus.m_valid}, {63'd0, e_mv});
    check_eq("m_err", {63'd0, bus.m_err}, {63'd0, e_me});
    check_eq("m_rdata", bus.m_rdata, e_mr);
  endtask

  task automatic drive_inputs();
    // Fetch requester: may renew right at its valid pulse, occasionally squashes
    if (bus.f_req) begin
      if (e_fv) begin
        bus.f_req = 1'($urandom_range(0, 1));
        bus.f_addr = rnd64();
      end else if ($urandom_range(0, 19) == 0) begin
        bus.f_req = 1'b0;
      end
    end else if ($urandom_range(0, 2) == 0) begin
      bus.f_req = 1'b1;
      bus.f_addr = rnd64();
    end
    if (bus.m_req) begin
      if (e_mv) begin
        bus.m_req = 1'($urandom_range(0, 2) != 0);
        bus.m_we = 1'($urandom_range(0, 1));
        bus.m_addr = rnd64();
        bus.m_wdata = rnd64();
      end
    end else if ($urandom_range(0, 3) == 0) begin
      bus.m_req = 1'b1;
      bus.m_we = 1'($urandom_range(0, 1));
      bus.m_addr = rnd64();
      bus.m_wdata = rnd64();
    end
    bus.mem_rdata = rnd64();
    if (owner != 0) bus.mem_ack = ((cyc - grant_cyc) == ack_at);
    else            bus.mem_ack = ($urandom_range(0, 3) == 0);
  endtask

  task automatic pick_ack_delay();
    case ($urandom_range(0, 9))
      0, 1, 2: ack_at = 0;
      3, 4:    ack_at = 1;
      5:       ack_at = 2;
      6:       ack_at = TIMEOUT - 2;
      7:       ack_at = TIMEOUT - 1;
      8:       ack_at = NEVER;
      default: ack_at = 3;
    endcase
  endtask

  // Advance the model across the coming clock edge using the inputs now applied
  task automatic model_step();
    logic f_ok, m_ok, force_f;
    int   age;
    f_ok = bus.f_req && !e_fv;
    m_ok = bus.m_req && !e_mv;
    e_fv = 1'b0; e_fe = 1'b0; e_fr = '0;
    e_mv = 1'b0; e_me = 1'b0; e_mr = '0;
    if (owner == 0) begin
      force_f = 1'b0;
`ifdef FETCH_STARVE_GUARD_EN
      force_f = f_ok && (starve >= STARVE_MAX);
`endif
      if (m_ok && !force_f) begin
        owner = 2; e_we = bus.m_we; e_addr = bus.m_addr; e_wdata = bus.m_wdata;
        if (f_ok && starve < STARVE_MAX) starve++;
        grant_cyc = cyc + 1;
        pick_ack_delay();
      end else if (f_ok) begin
        owner = 1; e_we = 1'b0; e_addr = bus.f_addr; e_wdata = '0;
        starve = 0;
        grant_cyc = cyc + 1;
        pick_ack_delay();
      end
    end else begin
      age = cyc - grant_cyc;
      if (bus.mem_ack || age == TIMEOUT - 1) begin
        if (owner == 1) begin
          e_fv = 1'b1; e_fe = !bus.mem_ack;
          e_fr = bus.mem_ack ? bus.mem_rdata : 64'd0;
        end else begin
          e_mv = 1'b1; e_me = !bus.mem_ack;
          e_mr = (bus.mem_ack && !e_we) ? bus.mem_rdata : 64'd0;
        end
        owner = 0;
      end
    end
  endtask

  initial begin
    bit did_mid_reset;
    did_mid_reset = 1'b0;
    cyc = 0;
    rst = 1'b1;
    clear_inputs();
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs();
    rst = 1'b0;

    for (int i = 0; i < N_CYCLES; i++) begin
      check_outputs();
      if (!did_mid_reset && i > 1000 && (owner == 2 || i > 2500)) begin
        // Asynchronous reset in the middle of a transaction
        did_mid_reset = 1'b1;
        rst = 1'b1;
        #1;
        check_eq("rst_mem_req", {63'd0, bus.mem_req}, 64'd0);
        check_eq("rst_f_valid", {63'd0, bus.f_valid}, 64'd0);
        check_eq("rst_m_valid", {63'd0, bus.m_valid}, 64'd0);
        clear_inputs();
        model_reset();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        rst = 1'b0;
        continue;
      end
      drive_inputs();
      #1;
      check_eq("f_wait", {63'd0, bus.f_wait}, {63'd0, bus.f_req && !e_fv});
      check_eq("m_wait", {63'd0, bus.m_wait}, {63'd0, bus.m_req && !e_mv});
      model_step();
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
